// File: rtl/net_cell_scheduler.sv
// Frame sequencer: loads FRAME_LEN words onto the cell bus, starts all cells, gathers dones, streams results.
// Latency >= FRAME_LEN+C_NET_CELL_COUNT+4 cycles per frame; s_axis stalls outside LOAD, results hold while m_axis_tready=0.
module net_cell_scheduler #(
  parameter int C_NET_CELL_COUNT = 10,
  parameter int C_TDATA_WIDTH    = 32
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  input  logic                                      enable,
  input  logic                                      clear,
  input  logic [C_TDATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic                                      s_axis_tvalid,
  input  logic                                      s_axis_tlast,
  output logic                                      s_axis_tready,
  output logic                                      load_valid,
  output logic [C_TDATA_WIDTH-1:0]                  load_data,
  output logic [7:0]                                load_index,
  output logic                                      cell_start,
  input  logic [C_NET_CELL_COUNT-1:0]               cell_done,
  input  logic [C_NET_CELL_COUNT*C_TDATA_WIDTH-1:0] cell_result,
  output logic [C_TDATA_WIDTH-1:0]                  m_axis_tdata,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [2:0]                                status,
  output logic                                      completed,
  output logic                                      err,
  output logic [31:0]                               debug_write_pointer,
  output logic [31:0]                               debug_read_pointer
);

  localparam int         FRAME_LEN = 9 + (C_NET_CELL_COUNT - 1) * 3;
  localparam logic [7:0] LAST_WR   = 8'(FRAME_LEN - 1);
  localparam logic [7:0] LAST_RD   = 8'(C_NET_CELL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                      state_q, state_d;
  logic [7:0]                  wr_ptr_q, wr_ptr_d;
  logic [7:0]                  rd_ptr_q, rd_ptr_d;
  logic [C_NET_CELL_COUNT-1:0] done_mask_q, done_mask_d;
  logic                        err_q, err_d;
  logic                        out_beat;

  // Handshake outputs decode from state only; areset forces them low while it is asserted.
  assign s_axis_tready = (state_q == S_LOAD) && !areset;
  assign m_axis_tvalid = (state_q == S_SEND) && !areset;
  assign m_axis_tlast  = m_axis_tvalid && (rd_ptr_q == LAST_RD);
  assign cell_start    = (state_q == S_START) && !areset;
  assign completed     = (state_q == S_DONE) && !areset;

  assign load_valid = s_axis_tvalid && s_axis_tready;
  assign load_data  = s_axis_tdata;
  assign load_index = wr_ptr_q;
  assign out_beat   = m_axis_tvalid && m_axis_tready;

  assign status              = state_q;
  assign err                 = err_q;
  assign debug_write_pointer = {24'd0, wr_ptr_q};
  assign debug_read_pointer  = {24'd0, rd_ptr_q};

  always_comb begin
    m_axis_tdata = '0;
    for (int k = 0; k < C_NET_CELL_COUNT; k++) begin
      if (rd_ptr_q == 8'(k)) m_axis_tdata = cell_result[k*C_TDATA_WIDTH +: C_TDATA_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    done_mask_d = done_mask_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          wr_ptr_d = wr_ptr_q + 8'd1;
          if (wr_ptr_q == LAST_WR) begin
            state_d = S_START;
          end else if (s_axis_tlast) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_START: begin
        // Fresh mask, but a cell finishing in the start cycle still counts.
        done_mask_d = cell_done;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        done_mask_d = done_mask_q | cell_done;
        if (&(done_mask_q | cell_done)) begin
          state_d  = S_SEND;
          rd_ptr_d = '0;
        end
      end
      S_SEND: begin
        if (out_beat) begin
          if (rd_ptr_q == LAST_RD) state_d = S_DONE;
          else                     rd_ptr_d = rd_ptr_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      done_mask_d = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_mask_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_mask_q <= done_mask_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_net_cell_scheduler.sv
// Directed bench for net_cell_scheduler: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
module tb_net_cell_scheduler;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int FL = 9 + (N - 1) * 3;

  logic           aclk = 1'b0;
  logic           areset, enable, clear;
  logic [W-1:0]   s_axis_tdata;
  logic           s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic           load_valid;
  logic [W-1:0]   load_data;
  logic [7:0]     load_index;
  logic           cell_start;
  logic [N-1:0]   cell_done;
  logic [N*W-1:0] cell_result;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [2:0]     status;
  logic           completed, err;
  logic [31:0]    debug_write_pointer, debug_read_pointer;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  always #5 aclk = ~aclk;

  net_cell_scheduler #(.C_NET_CELL_COUNT(N), .C_TDATA_WIDTH(W)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .clear(clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .load_valid(load_valid), .load_data(load_data),
    .load_index(load_index), .cell_start(cell_start), .cell_done(cell_done),
    .cell_result(cell_result), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .status(status),
    .completed(completed), .err(err), .debug_write_pointer(debug_write_pointer),
    .debug_read_pointer(debug_read_pointer)
  );

  function automatic logic [W-1:0] res_word(input int k);
    return 32'h5000_0000 + 32'(k) * 32'h111;
  endfunction

  task automatic cyc();
    @(posedge aclk);
    #1;
    cyc_cnt++;
  endtask

  // IDLE cycle with enable raised; the next cycle is LOAD.
  task automatic begin_frame();
    enable = 1'b1;
    #1;
    total++; if (status !== 3'd0 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL idle_before_load got status=%0d tready=%b want 0 0", status, s_axis_tready); end
    cyc();
  endtask

  task automatic load_frame(input int n_beats, input int tlast_at, input logic [W-1:0] base);
    for (int i = 0; i < n_beats; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 32'(i);
      s_axis_tlast  = (i == tlast_at);
      #1;
      total++; if (status !== 3'd1 || s_axis_tready !== 1'b1 || load_valid !== 1'b1 || cell_start !== 1'b0) begin bad++; $display("FAIL load_hs beat=%0d got status=%0d tready=%b lv=%b start=%b want 1 1 1 0", i, status, s_axis_tready, load_valid, cell_start); end
      total++; if (load_index !== 8'(i) || load_data !== base + 32'(i)) begin bad++; $display("FAIL load_word beat=%0d got idx=%0d data=%h want %0d %h", i, load_index, load_data, i, base + 32'(i)); end
      cyc();
      enable = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic start_wait(input logic [N-1:0] start_done, input int wait_cycles, input logic [N-1:0] last_done);
    cell_done = start_done;
    #1;
    total++; if (cell_start !== 1'b1 || status !== 3'd2) begin bad++; $display("FAIL start_pulse got start=%b status=%0d want 1 2", cell_start, status); end
    cyc();
    for (int k = 0; k < wait_cycles; k++) begin
      cell_done = (k == wait_cycles - 1) ? last_done : '0;
      #1;
      total++; if (cell_start !== 1'b0 || status !== 3'd3) begin bad++; $display("FAIL wait_state k=%0d got start=%b status=%0d want 0 3", k, cell_start, status); end
      cyc();
    end
    cell_done = '0;
  endtask

  // Ends at the IDLE cycle following DONE, after sampling it.
  task automatic send_frame(input bit toggle);
    int b = 0;
    int n = 0;
    while (b < N && n < 4 * N) begin
      m_axis_tready = toggle ? (n % 2 == 0) : 1'b1;
      #1;
      total++; if (m_axis_tvalid !== 1'b1 || status !== 3'd4) begin bad++; $display("FAIL send_valid beat=%0d got tvalid=%b status=%0d want 1 4", b, m_axis_tvalid, status); end
      total++; if (m_axis_tdata !== res_word(b) || m_axis_tlast !== (b == N - 1)) begin bad++; $display("FAIL send_data beat=%0d got data=%h last=%b want %h %b", b, m_axis_tdata, m_axis_tlast, res_word(b), b == N - 1); end
      if (m_axis_tready) b++;
      n++;
      cyc();
      cell_done = '0;
    end
    m_axis_tready = 1'b1;
    total++; if (b != N) begin bad++; $display("FAIL send_count got %0d beats want %0d", b, N); end
    #1;
    total++; if (completed !== 1'b1 || status !== 3'd5 || debug_read_pointer !== 32'(N - 1) || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL done_state got cmp=%b status=%0d rd=%0d tvalid=%b want 1 5 %0d 0", completed, status, debug_read_pointer, m_axis_tvalid, N - 1); end
    cyc();
    #1;
    total++; if (completed !== 1'b0 || status !== 3'd0) begin bad++; $display("FAIL after_done got cmp=%b status=%0d want 0 0", completed, status); end
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    #1;
    total++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || cell_start !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL reset_outputs got tr=%b tv=%b tl=%b st=%b lv=%b want all 0", s_axis_tready, m_axis_tvalid, m_axis_tlast, cell_start, load_valid); end
    total++; if (status !== 3'd0 || err !== 1'b0 || completed !== 1'b0 || debug_write_pointer !== 32'd0 || debug_read_pointer !== 32'd0) begin bad++; $display("FAIL reset_state got status=%0d err=%b cmp=%b wr=%0d rd=%0d want 0", status, err, completed, debug_write_pointer, debug_read_pointer); end
    cyc();
    areset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_frame();
    int c0;
    c0 = cyc_cnt;
    begin_frame();
    load_frame(FL, FL - 1, 32'd0);
    start_wait('0, 3, '1);
    send_frame(1'b0);
    total++; if (cyc_cnt - c0 != 52) begin bad++; $display("FAIL frame_cycles got %0d want 52", cyc_cnt - c0); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got %b want 0", err); end
    cyc();
  endtask

  task automatic test_backpressure();
    begin_frame();
    load_frame(FL, FL - 1, 32'h100);
    start_wait('1, 1, '0);
    send_frame(1'b1);
    cyc();
  endtask

  task automatic test_staggered_done();
    begin_frame();
    load_frame(FL, FL - 1, 32'h200);
    cell_done = '0;
    #1;
    total++; if (cell_start !== 1'b1) begin bad++; $display("FAIL stag_start got %b want 1", cell_start); end
    cyc();
    for (int k = 0; k < N; k++) begin
      cell_done = '0;
      cell_done[k] = 1'b1;
      #1;
      total++; if (status !== 3'd3) begin bad++; $display("FAIL stag_wait k=%0d got status=%0d want 3", k, status); end
      cyc();
    end
    cell_done = '0;
    cell_done[N-1] = 1'b1;
    send_frame(1'b0);
    cyc();
    #1;
    total++; if (status !== 3'd0 || cell_start !== 1'b0) begin bad++; $display("FAIL stag_idle got status=%0d start=%b want 0 0", status, cell_start); end
    cyc();
  endtask

  task automatic test_early_tlast();
    begin_frame();
    load_frame(21, 20, 32'h300);
    #1;
    total++; if (status !== 3'd0 || err !== 1'b1 || cell_start !== 1'b0 || s_axis_tready !== 1'b0) begin bad++; $display("FAIL early_abort got status=%0d err=%b start=%b tready=%b want 0 1 0 0", status, err, cell_start, s_axis_tready); end
    cyc();
    #1;
    total++; if (status !== 3'd0 || cell_start !== 1'b0) begin bad++; $display("FAIL early_idle got status=%0d start=%b want 0 0", status, cell_start); end
    cyc();
    begin_frame();
    load_frame(FL, FL - 1, 32'h400);
    start_wait('1, 1, '0);
    send_frame(1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err_sticky got %b want 1", err); end
    cyc();
  endtask

  task automatic test_clear_send();
    begin_frame();
    load_frame(FL, FL - 1, 32'h500);
    start_wait('0, 1, '1);
    for (int b = 0; b < 4; b++) begin
      m_axis_tready = 1'b1;
      #1;
      total++; if (m_axis_tdata !== res_word(b)) begin bad++; $display("FAIL clr_data beat=%0d got %h want %h", b, m_axis_tdata, res_word(b)); end
      cyc();
    end
    clear = 1'b1;
    #1;
    total++; if (debug_read_pointer !== 32'd4 || status !== 3'd4) begin bad++; $display("FAIL clr_pre got rd=%0d status=%0d want 4 4", debug_read_pointer, status); end
    cyc();
    clear = 1'b0;
    #1;
    total++; if (status !== 3'd0 || m_axis_tvalid !== 1'b0 || debug_write_pointer !== 32'd0 || debug_read_pointer !== 32'd0) begin bad++; $display("FAIL clr_post got status=%0d tvalid=%b wr=%0d rd=%0d want 0 0 0 0", status, m_axis_tvalid, debug_write_pointer, debug_read_pointer); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL clr_err_kept got %b want 1", err); end
    cyc();
  endtask

  task automatic test_reset_load();
    begin_frame();
    load_frame(17, -1, 32'h600);
    enable = 1'b1;
    s_axis_tvalid = 1'b1;
    #1;
    total++; if (debug_write_pointer !== 32'd17 || status !== 3'd1) begin bad++; $display("FAIL rst_pre got wr=%0d status=%0d want 17 1", debug_write_pointer, status); end
    areset = 1'b1;
    #1;
    total++; if (s_axis_tready !== 1'b0 || load_valid !== 1'b0) begin bad++; $display("FAIL rst_gate got tready=%b lv=%b want 0 0", s_axis_tready, load_valid); end
    cyc();
    #1;
    total++; if (status !== 3'd0 || err !== 1'b0 || completed !== 1'b0 || debug_write_pointer !== 32'd0 || debug_read_pointer !== 32'd0 || m_axis_tvalid !== 1'b0 || cell_start !== 1'b0) begin bad++; $display("FAIL rst_state got status=%0d err=%b cmp=%b wr=%0d rd=%0d tv=%b st=%b want 0", status, err, completed, debug_write_pointer, debug_read_pointer, m_axis_tvalid, cell_start); end
    cyc();
    areset = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (s_axis_tready !== 1'b0 || status !== 3'd0) begin bad++; $display("FAIL rst_hold k=%0d got tready=%b status=%0d want 0 0", k, s_axis_tready, status); end
    end
    enable = 1'b1;
    #1;
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_idle_tready got %b want 0", s_axis_tready); end
    cyc();
    #1;
    total++; if (s_axis_tready !== 1'b1 || status !== 3'd1 || load_index !== 8'd0) begin bad++; $display("FAIL rst_reload got tready=%b status=%0d idx=%0d want 1 1 0", s_axis_tready, status, load_index); end
    cyc();
    enable = 1'b0;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    areset = 1'b1; enable = 1'b0; clear = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cell_done = '0; m_axis_tready = 1'b1;
    for (int k = 0; k < N; k++) cell_result[k*W +: W] = res_word(k);
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_staggered_done();
    test_early_tlast();
    test_clear_send();
    test_reset_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
